// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with PC, one-entry instruction register and valid/ready handoff
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   rom_addr / rom_data           ROM address (equals pc) and combinational ROM word
//   redirect_valid/redirect_addr  one-cycle jump request from execute
//   ir_valid/ir_ready             handshake to decode
//   ir_data/ir_pc                 held instruction and the address it came from
//   pc                            next address to fetch
//   done                          last word accepted and fetch has stopped
// Optional feature: define FETCH_WRAP_EN to wrap pc to 0 after the last word instead of stopping.
module fetch_unit #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    input  logic          redirect_valid,
    input  logic [AW-1:0] redirect_addr,
    output logic          ir_valid,
    input  logic          ir_ready,
    output logic [DW-1:0] ir_data,
    output logic [AW-1:0] ir_pc,
    output logic [AW-1:0] pc,
    output logic          done
);
    typedef enum logic {S_FETCH, S_END} state_t;
    state_t state;
    logic   load;
    localparam logic [AW-1:0] LAST = '1;
    assign load     = (state == S_FETCH) && (!ir_valid || ir_ready);
    assign rom_addr = pc;
`ifdef FETCH_WRAP_EN
    assign done = 1'b0;
`else
    assign done = (state == S_END) && !ir_valid;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            ir_valid <= 1'b0;
            ir_data  <= '0;
            ir_pc    <= '0;
        end else if (redirect_valid) begin
            // redirect wins over load; any same-cycle handshake is still consumed
            state    <= S_FETCH;
            pc       <= redirect_addr;
            ir_valid <= 1'b0;
        end else if (load) begin
            ir_data  <= rom_data;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
`ifdef FETCH_WRAP_EN
            pc       <= pc + 1'b1;
`else
            if (pc == LAST) state <= S_END;
            else pc <= pc + 1'b1;
`endif
        end else if (ir_valid && ir_ready) begin
            ir_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps plus random traffic checked against a behavioural model
module tb_fetch_unit;
    localparam int AW = 3;
    localparam int DW = 16;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_addr = '0;
    logic          ir_ready = 1'b0;
    logic [AW-1:0] rom_addr, ir_pc, pc;
    logic [DW-1:0] rom_data, ir_data;
    logic          ir_valid, done;
    logic [DW-1:0] rom [8] = '{16'h9005, 16'h910A, 16'h5201, 16'h3301,
                               16'h4401, 16'h1703, 16'h1804, 16'h7F78};
    int tests = 0, fails = 0;
    int m_pc = 0, m_irpc = 0;
    bit m_valid = 0, m_end = 0;
    logic [DW-1:0] m_data = '0;
    int seen3301 = 0;

    fetch_unit #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_data(rom_data),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data),
        .ir_pc(ir_pc), .pc(pc), .done(done)
    );

    assign rom_data = rom[rom_addr];
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst && ir_valid && ir_ready && ir_data == 16'h3301) seen3301++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one clock: the model applies the fetch rules to the pre-edge state, then all outputs are compared
    task automatic cycle();
        bit hs;
        hs = m_valid && ir_ready;
        if (rst) begin
            m_pc = 0; m_irpc = 0; m_valid = 0; m_end = 0; m_data = '0;
        end else if (redirect_valid) begin
            m_pc = int'(redirect_addr); m_valid = 0; m_end = 0;
        end else if (!m_end && (!m_valid || ir_ready)) begin
            m_data = rom[m_pc]; m_irpc = m_pc; m_valid = 1;
`ifdef FETCH_WRAP_EN
            m_pc = (m_pc + 1) % 8;
`else
            if (m_pc == 7) m_end = 1;
            else m_pc = m_pc + 1;
`endif
        end else if (hs) m_valid = 0;
        @(posedge clk); #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("rom_addr", 32'(rom_addr), 32'(m_pc));
        chk("ir_valid", 32'(ir_valid), 32'(m_valid));
        chk("ir_data", 32'(ir_data), 32'(m_data));
        chk("ir_pc", 32'(ir_pc), 32'(m_irpc));
        chk("done", 32'(done), 32'(m_end && !m_valid));
    endtask

    initial begin
        int n;
        cycle(); cycle();
        chk("reset_pc", 32'(pc), 0);
        chk("reset_valid", 32'(ir_valid), 0);
        chk("reset_done", 32'(done), 0);
        // streaming
        rst = 0; ir_ready = 1;
        cycle();
        for (int i = 0; i < 8; i++) begin
            chk("stream_data", 32'(ir_data), 32'(rom[i]));
            chk("stream_pc", 32'(ir_pc), i);
            chk("stream_valid", 32'(ir_valid), 1);
            cycle();
        end
`ifdef FETCH_WRAP_EN
        chk("wrap_data", 32'(ir_data), 32'h9005);
        chk("wrap_pc", 32'(ir_pc), 0);
`else
        chk("end_valid", 32'(ir_valid), 0);
        chk("end_done", 32'(done), 1);
        chk("end_pc", 32'(pc), 7);
        // redirect out of END
        redirect_valid = 1; redirect_addr = 3'd2;
        cycle();
        redirect_valid = 0;
        chk("redir_end_done", 32'(done), 0);
        cycle();
        chk("redir_end_data", 32'(ir_data), 32'h5201);
        chk("redir_end_valid", 32'(ir_valid), 1);
`endif
        // reset mid-run at pc==4
        n = 0;
        while (pc != 3'd4 && n < 20) begin cycle(); n++; end
        chk("reach_pc4", 32'(pc), 4);
        rst = 1;
        cycle();
        rst = 0;
        chk("midrst_pc", 32'(pc), 0);
        chk("midrst_valid", 32'(ir_valid), 0);
        chk("midrst_data", 32'(ir_data), 0);
        cycle();
        chk("refetch_data", 32'(ir_data), 32'h9005);
        // backpressure on 910A
        cycle();
        chk("bp_first", 32'(ir_data), 32'h910A);
        ir_ready = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_data", 32'(ir_data), 32'h910A);
            chk("bp_irpc", 32'(ir_pc), 1);
            chk("bp_pc", 32'(pc), 2);
        end
        ir_ready = 1;
        cycle();
        chk("bp_release", 32'(ir_data), 32'h5201);
        // redirect while 5201 held
        ir_ready = 0; redirect_valid = 1; redirect_addr = 3'd5;
        cycle();
        redirect_valid = 0;
        chk("redir_valid", 32'(ir_valid), 0);
        chk("redir_pc", 32'(pc), 5);
        cycle();
        chk("redir_data", 32'(ir_data), 32'h1703);
        chk("redir_irpc", 32'(ir_pc), 5);
        // simultaneous handshake and redirect while 3301 held
        redirect_valid = 1; redirect_addr = 3'd3;
        cycle();
        redirect_valid = 0;
        cycle();
        chk("hold3301", 32'(ir_data), 32'h3301);
        seen3301 = 0;
        ir_ready = 1; redirect_valid = 1; redirect_addr = 3'd0;
        cycle();
        redirect_valid = 0;
        chk("sim_valid", 32'(ir_valid), 0);
        chk("sim_pc", 32'(pc), 0);
        cycle();
        chk("sim_consumed_once", 32'(seen3301), 1);
        chk("sim_data", 32'(ir_data), 32'h9005);
        chk("sim_irpc", 32'(ir_pc), 0);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) == 0);
            ir_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 9) == 0);
            redirect_addr = 3'($urandom);
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
